mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
MEM-stage initiator that drives the word-only data RAM (11-bit word address, 32-bit data, registered 1-cycle read, synchronous write) on behalf of the core's load/store path.
- Converts byte-addressed load/store requests of byte, half and word size into RAM cycles.
- Sub-word stores use read-modify-write.
- Loads are sign- or zero-extended.
- Misaligned or out-of-range requests are reported as errors without touching memory.

Parameters:
- ADDR_W, 11, RAM word-address width; byte address space is 2^(ADDR_W+2) bytes.
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  request present; sampled only when req_ready=1.
- req_ready  out  1  controller idle and able to accept.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified for byte/half.
- rsp_valid  out  1  one-cycle pulse, request complete.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid: misaligned, reserved size, or out of range.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid the cycle after mem_read.
- mem_read  out  1  RAM read enable.
- mem_write  out  1  RAM write enable.

Behaviour:
- States: IDLE, READ, RWAIT, WRITE, RESP. req_ready=1 only in IDLE.
- Accept in IDLE when req_valid=1; latch we/size/signed/addr/wdata. Ignore req_valid in every other state.
- Error conditions, checked at accept:
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]!=00;
  - addr[31:ADDR_W+2]!=0.
  - On error go to RESP with rsp_err=1. No mem_read or mem_write is ever issued.
- Word store: IDLE->WRITE->RESP.
- Load or sub-word store: IDLE->READ->RWAIT.
  - Load: RWAIT->RESP.
  - Sub-word store: RWAIT->WRITE->RESP.
- READ: mem_read=1 and mem_addr=addr[ADDR_W+1:2].
- RWAIT:
  - Capture mem_rdata.
  - Load: select lane and extend into rsp_rdata register.
  - Store: merge the new byte/half into the captured word and place the result in the write buffer.
- WRITE: mem_write=1, mem_wdata=write buffer.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. A new request can be accepted the cycle after RESP.
- Latency, with accept at cycle T, gives rsp_valid at:
  - word store T+2;
  - load T+3;
  - sub-word store T+4;
  - error T+1.
- Lanes are little-endian.
  - Byte k (k=addr[1:0]) occupies bits [8k+7:8k].
  - Half occupies bits [15:0] if addr[1]=0, else [31:16].
  - Word loads ignore req_signed.
- A sub-word store modifies only the addressed lanes; all other lanes are written back unchanged.
- mem_read/mem_write are 0 outside READ/WRITE. Both are also gated by ~rst, so a write in flight when rst rises is suppressed.
- Reset (synchronous): state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_addr=0, mem_wdata=0, mem_read=0, mem_write=0, req_ready=1 on the cycle after rst falls.
  - Reset mid-operation aborts the request with no response.
  - An RMW aborted before WRITE leaves memory unmodified.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD;
  - state encoding;
  - lane-select helper constants.
- One combinational sub-module, mem_lane_align: inputs word, addr[1:0], size, signed, wdata; outputs load_data and merged_word. Shared by the load and RMW paths.

Test Plan:
- RAM word 5 = 0x8899AABB, load byte signed at addr 0x16 -> rsp_rdata=0xFFFFFF99 at T+3, rsp_err=0; unsigned -> 0x00000099.
- Store word 0xDEADBEEF at 0x20 -> mem_write at T+1 with mem_addr=8; rsp_valid at T+2; word load at 0x20 returns 0xDEADBEEF.
- RAM word 3 = 0x11223344, store half 0xCAFE at 0x0E -> READ T+1, WRITE T+3 with mem_wdata=0xCAFE3344, rsp_valid T+4.
- Load word at 0x02 and load at 0x2000 (out of range) -> rsp_valid at T+1 with rsp_err=1; mem_read and mem_write never asserted.
- Assert rst during RWAIT of a byte store -> no mem_write, RAM word unchanged, rsp_valid never pulses, req_ready=1 the cycle after rst falls.
- req_valid held high across a load -> exactly one acceptance, next accept the cycle after RESP; back-to-back requests complete in order.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage data RAM controller: request sizes,
// FSM states and the byte-lane masks used by loads and read-modify-write stores.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_RWAIT = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic [3:0] LANES_BYTE = 4'b0001;
  localparam logic [3:0] LANES_HALF = 4'b0011;
  localparam logic [3:0] LANES_WORD = 4'b1111;

  // Little-endian lane mask touched by an access of the given size and offset.
  function automatic logic [3:0] lane_mask(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: lane_mask = LANES_BYTE << off;
      SZ_HALF: lane_mask = off[1] ? (LANES_HALF << 2) : LANES_HALF;
      default: lane_mask = LANES_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: extracts/extends load data from a RAM word and
// merges right-justified store data into a RAM word for read-modify-write.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  size_t       size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] rep_data;
  logic [3:0]  mask;

  always_comb begin
    byte_lane = word[7:0];
    case (offset)
      2'd0: byte_lane = word[7:0];
      2'd1: byte_lane = word[15:8];
      2'd2: byte_lane = word[23:16];
      2'd3: byte_lane = word[31:24];
      default: byte_lane = word[7:0];
    endcase
  end

  assign half_lane = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_data = word;
    case (size)
      SZ_BYTE: load_data = {{24{is_signed & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data = {{16{is_signed & half_lane[15]}}, half_lane};
      default: load_data = word;
    endcase
  end

  // Replicating the store data across the word lets each lane pick from the same slot.
  always_comb begin
    rep_data = wdata;
    case (size)
      SZ_BYTE: rep_data = {4{wdata[7:0]}};
      SZ_HALF: rep_data = {2{wdata[15:0]}};
      default: rep_data = wdata;
    endcase
  end

  assign mask = lane_mask(size, offset);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = mask[gi] ? rep_data[8*gi +: 8] : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller for a word-only RAM with 1-cycle registered
// read; handles byte/half/word accesses, sub-word RMW stores and error checks.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write
);

  state_t            state_reg, state_next;
  size_t             req_sz;
  size_t             size_reg;
  logic              we_reg;
  logic              signed_reg;
  logic [ADDR_W+1:0] addr_reg;
  logic [DATA_W-1:0] wbuf_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;
  logic              misalign;
  logic              out_of_range;
  logic              req_err;
  logic              accept;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged_word;

  assign req_sz = size_t'(req_size);

  always_comb begin
    misalign = 1'b0;
    case (req_sz)
      SZ_HALF: misalign = req_addr[0];
      SZ_WORD: misalign = |req_addr[1:0];
      SZ_RSVD: misalign = 1'b1;
      default: misalign = 1'b0;
    endcase
  end

  assign out_of_range = |req_addr[31:ADDR_W+2];
  assign req_err      = misalign | out_of_range;
  assign accept       = (state_reg == ST_IDLE) & req_valid;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_err)                         state_next = ST_RESP;
          else if (req_we && req_sz == SZ_WORD) state_next = ST_WRITE;
          else                                 state_next = ST_READ;
        end
      end
      ST_READ:  state_next = ST_RWAIT;
      ST_RWAIT: state_next = we_reg ? ST_WRITE : ST_RESP;
      ST_WRITE: state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // RAM strobes are masked by rst so an in-flight write cannot land during reset.
  always_comb begin
    req_ready = (state_reg == ST_IDLE);
    mem_read  = (state_reg == ST_READ) & ~rst;
    mem_write = (state_reg == ST_WRITE) & ~rst;
    rsp_valid = (state_reg == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg     <= 1'b0;
      size_reg   <= SZ_BYTE;
      signed_reg <= 1'b0;
      addr_reg   <= '0;
      wbuf_reg   <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else if (accept) begin
      we_reg     <= req_we;
      size_reg   <= req_sz;
      signed_reg <= req_signed;
      addr_reg   <= req_addr[ADDR_W+1:0];
      wbuf_reg   <= req_wdata;
      rdata_reg  <= '0;
      err_reg    <= req_err;
    end else if (state_reg == ST_RWAIT) begin
      if (we_reg) wbuf_reg  <= merged_word;
      else        rdata_reg <= load_data;
    end
  end

  mem_lane_align u_align (
    .word        (mem_rdata),
    .offset      (addr_reg[1:0]),
    .size        (size_reg),
    .is_signed   (signed_reg),
    .wdata       (wbuf_reg),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  assign mem_addr  = addr_reg[ADDR_W+1:2];
  assign mem_wdata = wbuf_reg;
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

endmodule
